// File: rtl/shift_counter_gen_if.sv
// Control and status bundle for shift_counter_gen: stepping controls in,
// counter state, phase index and event pulses out.
interface shift_counter_gen_if #(
  parameter int WIDTH = 4
);
  localparam int PW = $clog2(2 * WIDTH);

  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [PW-1:0]    phase;
  logic             wrap;
  logic             illegal;

  modport master (
    output en, mode, dir, load, load_val,
    input  count, phase, wrap, illegal
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output count, phase, wrap, illegal
  );
endinterface

// File: rtl/shift_counter_gen.sv
// WIDTH-bit Johnson/ring shift counter with direction, enable, parallel load,
// illegal-state self-correction, registered binary phase and wrap pulse.
module shift_counter_gen #(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2 * WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_counter_gen_if.slave   bus
);

  logic [WIDTH-1:0] count_q, next_count, home;
  logic [PW-1:0]    phase_q;
  logic             wrap_q, illegal_q;
  logic             next_wrap, next_illegal;

  // Johnson codes have at most one 0/1 boundary between adjacent bits;
  // ring codes are exactly one-hot.
  function automatic logic is_legal(input logic m, input logic [WIDTH-1:0] v);
    int edges;
    edges = 0;
    if (m) return ($countones(v) == 1);
    for (int i = 0; i < WIDTH - 1; i++)
      if (v[i] != v[i+1]) edges++;
    return (edges <= 1);
  endfunction

  function automatic logic [PW-1:0] phase_of(input logic m, input logic [WIDTH-1:0] v);
    int k;
    logic [PW-1:0] p;
    p = '0;
    if (m) begin
      for (int i = 0; i < WIDTH; i++)
        if (v[i]) p = PW'(i);
    end else begin
      k = $countones(v);
      p = v[WIDTH-1] ? PW'(2 * WIDTH - k) : PW'(k);
    end
    return p;
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    home         = bus.mode ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
    next_count   = count_q;
    next_wrap    = 1'b0;
    next_illegal = 1'b0;
    if (bus.load) begin
      if (is_legal(bus.mode, bus.load_val)) begin
        next_count = bus.load_val;
      end else begin
        next_count   = home;
        next_illegal = 1'b1;
      end
    end else if (!is_legal(bus.mode, count_q)) begin
      next_count   = home;
      next_illegal = 1'b1;
    end else if (bus.en) begin
      case ({bus.mode, bus.dir})
        2'b00:   next_count = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
        2'b01:   next_count = {~count_q[0], count_q[WIDTH-1:1]};
        2'b10:   next_count = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
        default: next_count = {count_q[0], count_q[WIDTH-1:1]};
      endcase
      next_wrap = (next_count == home);
    end
  end

  // Phase is derived from the value being registered, so it can never
  // drift from count.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= home;
      phase_q   <= '0;
      wrap_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      count_q   <= next_count;
      phase_q   <= phase_of(bus.mode, next_count);
      wrap_q    <= next_wrap;
      illegal_q <= next_illegal;
    end
  end

  assign bus.count   = count_q;
  assign bus.phase   = phase_q;
  assign bus.wrap    = wrap_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_shift_counter_gen.sv
// Self-checking bench for shift_counter_gen: directed scenarios plus random
// stimulus against a phase-indexed behavioural model (WIDTH=4 and WIDTH=5).
module tb_shift_counter_gen;

  typedef struct {
    logic [31:0] count;
    int          phase;
    logic        wrap;
    logic        ill;
  } mstate_t;

  logic    clk = 1'b0;
  logic    reset4, reset5;
  int      errors = 0;
  int      checks = 0;
  mstate_t s4, s5;

  shift_counter_gen_if #(.WIDTH(4)) if4 ();
  shift_counter_gen_if #(.WIDTH(5)) if5 ();

  shift_counter_gen #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset4), .bus(if4.slave));
  shift_counter_gen #(.WIDTH(5)) dut5 (.clk(clk), .reset(reset5), .bus(if5.slave));

  always #5 clk = ~clk;

  // Model: a counter state is just an index p into the mode's sequence.
  function automatic int n_states(input int w, input logic m);
    return m ? w : 2 * w;
  endfunction

  function automatic logic [31:0] cnt_of(input int w, input logic m, input int p);
    if (m) return 32'd1 << p;
    if (p <= w) return (32'd1 << p) - 32'd1;
    return ((32'd1 << (2 * w - p)) - 32'd1) << (p - w);
  endfunction

  function automatic int idx_of(input int w, input logic m, input logic [31:0] v);
    for (int p = 0; p < n_states(w, m); p++)
      if (cnt_of(w, m, p) == v) return p;
    return -1;
  endfunction

  function automatic mstate_t model_next(input int w, input mstate_t s, input logic rst,
                                         input logic en, input logic m, input logic dir,
                                         input logic ld, input logic [31:0] lv);
    mstate_t r;
    int      n, idx;
    n = n_states(w, m);
    r.count = s.count;
    r.wrap  = 1'b0;
    r.ill   = 1'b0;
    if (rst) begin
      r.count = cnt_of(w, m, 0);
    end else if (ld) begin
      if (idx_of(w, m, lv) >= 0) r.count = lv;
      else begin r.count = cnt_of(w, m, 0); r.ill = 1'b1; end
    end else if (idx_of(w, m, s.count) < 0) begin
      r.count = cnt_of(w, m, 0);
      r.ill   = 1'b1;
    end else if (en) begin
      idx     = (idx_of(w, m, s.count) + (dir ? n - 1 : 1)) % n;
      r.count = cnt_of(w, m, idx);
      r.wrap  = (idx == 0);
    end
    r.phase = idx_of(w, m, r.count);
    return r;
  endfunction

  // Advance both models with the inputs presented, then one clock edge;
  // outputs are sampled 1 time unit after the edge.
  task automatic tick();
    s4 = model_next(4, s4, reset4, if4.en, if4.mode, if4.dir, if4.load, 32'(if4.load_val));
    s5 = model_next(5, s5, reset5, if5.en, if5.mode, if5.dir, if5.load, 32'(if5.load_val));
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    reset4 = 1'b0; if4.en = 1'b0; if4.load = 1'b0; if4.dir = 1'b0; if4.load_val = '0;
  endtask

  task automatic test_reset();
    reset4 = 1'b1; reset5 = 1'b1; if4.mode = 1'b0; if5.mode = 1'b0;
    if4.en = 1'b1; if4.load = 1'b0; if4.dir = 1'b0; if4.load_val = '0;
    if5.en = 1'b0; if5.load = 1'b0; if5.dir = 1'b0; if5.load_val = '0;
    tick();
    checks++;
    if ({if4.count, if4.phase, if4.wrap, if4.illegal} !== {4'b0000, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_johnson: got count=%b phase=%0d wrap=%b ill=%b, want 0000/0/0/0",
               if4.count, if4.phase, if4.wrap, if4.illegal);
    end
    if4.mode = 1'b1;
    tick();
    checks++;
    if ({if4.count, if4.phase, if4.wrap, if4.illegal} !== {4'b0001, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ring: got count=%b phase=%0d wrap=%b ill=%b, want 0001/0/0/0",
               if4.count, if4.phase, if4.wrap, if4.illegal);
    end
    reset5 = 1'b0;
  endtask

  task automatic test_johnson_left();
    logic [3:0] exp_count [9];
    exp_count = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                  4'b1110, 4'b1100, 4'b1000, 4'b0000};
    if4.mode = 1'b0; reset4 = 1'b1;
    tick();
    idle4(); if4.en = 1'b1;
    for (int i = 1; i < 9; i++) begin
      tick();
      checks++;
      if (if4.count !== exp_count[i] || int'(if4.phase) !== i % 8 ||
          if4.wrap !== (i == 8) || if4.illegal !== 1'b0) begin
        errors++;
        $display("FAIL johnson_left[%0d]: got count=%b phase=%0d wrap=%b ill=%b, want %b/%0d/%b/0",
                 i, if4.count, if4.phase, if4.wrap, if4.illegal, exp_count[i], i % 8, (i == 8));
      end
    end
  endtask

  task automatic test_ring_right();
    logic [3:0] exp_count [5];
    int         exp_phase [5];
    exp_count = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    exp_phase = '{0, 3, 2, 1, 0};
    if4.mode = 1'b1; reset4 = 1'b1;
    tick();
    idle4(); if4.en = 1'b1; if4.dir = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++;
      if (if4.count !== exp_count[i] || int'(if4.phase) !== exp_phase[i] ||
          if4.wrap !== (i == 4) || if4.illegal !== 1'b0) begin
        errors++;
        $display("FAIL ring_right[%0d]: got count=%b phase=%0d wrap=%b, want %b/%0d/%b",
                 i, if4.count, if4.phase, if4.wrap, exp_count[i], exp_phase[i], (i == 4));
      end
    end
  endtask

  task automatic test_hold_load();
    if4.mode = 1'b0; reset4 = 1'b1;
    tick();
    idle4(); if4.en = 1'b1;
    repeat (3) tick();
    if4.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if4.count !== 4'b0111 || if4.phase !== 3'd3 || if4.wrap !== 1'b0 || if4.illegal !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got count=%b phase=%0d wrap=%b ill=%b, want 0111/3/0/0",
                 i, if4.count, if4.phase, if4.wrap, if4.illegal);
      end
    end
    if4.load = 1'b1; if4.load_val = 4'b1100;
    tick();
    checks++;
    if (if4.count !== 4'b1100 || if4.phase !== 3'd6 || if4.illegal !== 1'b0) begin
      errors++;
      $display("FAIL load_legal: got count=%b phase=%0d ill=%b, want 1100/6/0",
               if4.count, if4.phase, if4.illegal);
    end
    if4.load_val = 4'b0101;
    tick();
    if4.load = 1'b0;
    checks++;
    if (if4.count !== 4'b0000 || if4.phase !== 3'd0 || if4.illegal !== 1'b1 || if4.wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_illegal: got count=%b phase=%0d ill=%b wrap=%b, want 0000/0/1/0",
               if4.count, if4.phase, if4.illegal, if4.wrap);
    end
    tick();
    checks++;
    if (if4.illegal !== 1'b0 || if4.count !== 4'b0000) begin
      errors++;
      $display("FAIL load_illegal_pulse: got count=%b ill=%b, want 0000/0", if4.count, if4.illegal);
    end
  endtask

  task automatic test_mode_switch();
    if4.mode = 1'b0; reset4 = 1'b1;
    tick();
    idle4(); if4.en = 1'b1;
    repeat (2) tick();
    if4.mode = 1'b1;
    tick();
    checks++;
    if (if4.count !== 4'b0001 || if4.phase !== 3'd0 || if4.illegal !== 1'b1 || if4.wrap !== 1'b0) begin
      errors++;
      $display("FAIL mode_switch: got count=%b phase=%0d ill=%b wrap=%b, want 0001/0/1/0",
               if4.count, if4.phase, if4.illegal, if4.wrap);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({32'(if4.count), 32'(if4.phase), if4.wrap, if4.illegal} !== {s4.count, 32'(s4.phase), s4.wrap, s4.ill}) begin
        errors++;
        $display("FAIL ring_resume[%0d]: got count=%b phase=%0d wrap=%b ill=%b, want %b/%0d/%b/%b",
                 i, if4.count, if4.phase, if4.wrap, if4.illegal, s4.count[3:0], s4.phase, s4.wrap, s4.ill);
      end
    end
  endtask

  task automatic test_reset_override();
    if4.mode = 1'b0; reset4 = 1'b1;
    tick();
    idle4(); if4.en = 1'b1;
    repeat (5) tick();
    reset4 = 1'b1; if4.load = 1'b1; if4.load_val = 4'b0111;
    tick();
    idle4();
    checks++;
    if (if4.count !== 4'b0000 || if4.phase !== 3'd0 || if4.wrap !== 1'b0 || if4.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_override: got count=%b phase=%0d wrap=%b ill=%b, want 0000/0/0/0",
               if4.count, if4.phase, if4.wrap, if4.illegal);
    end
  endtask

  task automatic test_width5();
    int exp_p;
    if5.mode = 1'b0; reset5 = 1'b1;
    tick();
    reset5 = 1'b0; if5.en = 1'b1; if5.dir = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) if5.dir = 1'b1;
      tick();
      exp_p = (i <= 10) ? i % 10 : 20 - i;
      checks++;
      if (int'(if5.phase) !== exp_p || 32'(if5.count) !== cnt_of(5, 1'b0, exp_p) ||
          if5.wrap !== s5.wrap || if5.illegal !== 1'b0) begin
        errors++;
        $display("FAIL width5[%0d]: got count=%b phase=%0d wrap=%b, want %b/%0d/%b",
                 i, if5.count, if5.phase, if5.wrap, cnt_of(5, 1'b0, exp_p), exp_p, s5.wrap);
      end
    end
    if5.en = 1'b0;
    checks++;
    if (if5.count !== 5'b00000) begin
      errors++;
      $display("FAIL width5_return: got count=%b, want 00000", if5.count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset4   = ($urandom_range(31) == 0);
      if ($urandom_range(9) == 0) if4.mode = ~if4.mode;
      if4.en   = ($urandom_range(3) != 0);
      if4.dir  = $urandom_range(1);
      if4.load = ($urandom_range(5) == 0);
      if ($urandom_range(1) == 1)
        if4.load_val = 4'(cnt_of(4, if4.mode, $urandom_range(n_states(4, if4.mode) - 1)));
      else
        if4.load_val = 4'($urandom);
      tick();
      checks++;
      if ({32'(if4.count), 32'(if4.phase), if4.wrap, if4.illegal} !== {s4.count, 32'(s4.phase), s4.wrap, s4.ill}) begin
        errors++;
        $display("FAIL random[%0d]: got count=%b phase=%0d wrap=%b ill=%b, want %b/%0d/%b/%b",
                 i, if4.count, if4.phase, if4.wrap, if4.illegal, s4.count[3:0], s4.phase, s4.wrap, s4.ill);
      end
    end
    idle4();
  endtask

  initial begin
    s4 = '{count: '0, phase: 0, wrap: 1'b0, ill: 1'b0};
    s5 = '{count: '0, phase: 0, wrap: 1'b0, ill: 1'b0};
    test_reset();
    test_johnson_left();
    test_ring_right();
    test_hold_load();
    test_mode_switch();
    test_reset_override();
    test_width5();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
